// File: rtl/bus_region_decoder.sv
// Programmable address-region decoder with a strobe-driven access FSM.
// Handles wait-state insertion, timeout bus errors and aborts.
module bus_region_decoder #(
  parameter int unsigned N_REGIONS = 16,
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned WAIT_W    = 4,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned IDX_W     = $clog2(N_REGIONS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 as_n,
  input  logic                 rw,
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic                 cfg_en,
  input  logic [ADDR_W-1:0]    cfg_base,
  input  logic [ADDR_W-1:0]    cfg_mask,
  input  logic [WAIT_W-1:0]    cfg_wait,
  input  logic [1:0]           cfg_mode,
  output logic [N_REGIONS-1:0] cs,
  output logic                 cs_pulse,
  output logic [IDX_W-1:0]     hit_idx,
  output logic                 hit_valid,
  output logic                 dtack_n,
  output logic                 berr_n,
  output logic                 busy
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StDecode, StWait, StAck, StBerr} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic [WAIT_W-1:0]     wcnt_q, wcnt_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [N_REGIONS-1:0]  cs_q, cs_d;
  logic                  pulse_q, pulse_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  hv_q, hv_d;

  logic                  en_q   [N_REGIONS];
  logic [ADDR_W-1:0]     base_q [N_REGIONS];
  logic [ADDR_W-1:0]     mask_q [N_REGIONS];
  logic [WAIT_W-1:0]     wait_q [N_REGIONS];
  logic [1:0]            mode_q [N_REGIONS];

  logic [N_REGIONS-1:0]  hit_vec;
  logic                  any_hit;
  logic [IDX_W-1:0]      win_idx;
  logic [WAIT_W-1:0]     win_wait;
  logic                  berr_active;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_REGIONS; i++) begin
        en_q[i]   <= 1'b0;
        base_q[i] <= '0;
        mask_q[i] <= '0;
        wait_q[i] <= '0;
        mode_q[i] <= 2'b00;
      end
    end else if (cfg_we && (32'(cfg_idx) < N_REGIONS)) begin
      en_q[cfg_idx]   <= cfg_en;
      base_q[cfg_idx] <= cfg_base;
      mask_q[cfg_idx] <= cfg_mask;
      wait_q[cfg_idx] <= cfg_wait;
      mode_q[cfg_idx] <= cfg_mode;
    end
  end

  // Mode: 00 read+write, 01 read only, 10 write only, 11 never.
  always_comb begin
    hit_vec = '0;
    for (int unsigned i = 0; i < N_REGIONS; i++) begin
      hit_vec[i] = en_q[i] && (((addr_q ^ base_q[i]) & mask_q[i]) == '0) &&
                   ((mode_q[i] == 2'b00) || ((mode_q[i] == 2'b01) && rw_q) ||
                    ((mode_q[i] == 2'b10) && !rw_q));
    end
  end

  // Scan downwards so the lowest hitting index is the last one written.
  always_comb begin
    any_hit  = 1'b0;
    win_idx  = '0;
    win_wait = '0;
    for (int i = int'(N_REGIONS) - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        any_hit  = 1'b1;
        win_idx  = IDX_W'(i);
        win_wait = wait_q[i];
      end
    end
  end

  assign berr_active = (state_q == StBerr) && (tcnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    cs_d    = cs_q;
    idx_d   = idx_q;
    hv_d    = hv_q;
    pulse_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!as_n) begin
          addr_d  = addr;
          rw_d    = rw;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (as_n) begin
          state_d = StIdle;
        end else if (any_hit) begin
          cs_d    = {{(N_REGIONS-1){1'b0}}, 1'b1} << win_idx;
          idx_d   = win_idx;
          hv_d    = 1'b1;
          pulse_d = 1'b1;
          if (win_wait == '0) begin
            state_d = StAck;
          end else begin
            wcnt_d  = win_wait;
            state_d = StWait;
          end
        end else begin
          tcnt_d  = '0;
          state_d = StBerr;
        end
      end
      StWait: begin
        if (as_n) begin
          state_d = StIdle;
        end else if (wcnt_q == WAIT_W'(1)) begin
          state_d = StAck;
        end else begin
          wcnt_d = wcnt_q - WAIT_W'(1);
        end
      end
      StAck: begin
        if (as_n) state_d = StIdle;
      end
      StBerr: begin
        if (as_n) begin
          state_d = StIdle;
        end else if (!berr_active) begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d == StIdle) begin
      cs_d  = '0;
      idx_d = '0;
      hv_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      cs_q    <= '0;
      pulse_q <= 1'b0;
      idx_q   <= '0;
      hv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      cs_q    <= cs_d;
      pulse_q <= pulse_d;
      idx_q   <= idx_d;
      hv_q    <= hv_d;
    end
  end

  assign cs        = cs_q;
  assign cs_pulse  = pulse_q;
  assign hit_idx   = idx_q;
  assign hit_valid = hv_q;
  assign dtack_n   = !(state_q == StAck);
  assign berr_n    = !berr_active;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_bus_region_decoder.sv
// Self-checking bench for bus_region_decoder: directed scenarios plus randomized
// accesses checked against a behavioural region-table model.
module tb_bus_region_decoder;
  localparam int N  = 16;
  localparam int AW = 24;
  localparam int WW = 4;
  localparam int TO = 64;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset, as_n, rw, cfg_we, cfg_en;
  logic [AW-1:0] addr, cfg_base, cfg_mask;
  logic [IW-1:0] cfg_idx;
  logic [WW-1:0] cfg_wait;
  logic [1:0]    cfg_mode;
  logic [N-1:0]  cs;
  logic          cs_pulse, hit_valid, dtack_n, berr_n, busy;
  logic [IW-1:0] hit_idx;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference region table
  bit            m_en   [N];
  logic [AW-1:0] m_base [N];
  logic [AW-1:0] m_mask [N];
  int            m_wait [N];
  logic [1:0]    m_mode [N];

  // Observations from the last access
  int            r_ack, r_berr, r_pulses;
  logic [N-1:0]  r_cs;
  logic [IW-1:0] r_idx;
  logic          r_hv;
  bit            r_both, r_idle_ok;

  bus_region_decoder dut (
    .clk(clk), .reset(reset), .as_n(as_n), .rw(rw), .addr(addr),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_base(cfg_base),
    .cfg_mask(cfg_mask), .cfg_wait(cfg_wait), .cfg_mode(cfg_mode),
    .cs(cs), .cs_pulse(cs_pulse), .hit_idx(hit_idx), .hit_valid(hit_valid),
    .dtack_n(dtack_n), .berr_n(berr_n), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int model_hit(input logic [AW-1:0] a, input logic r);
    for (int i = 0; i < N; i++) begin
      if (m_en[i] && (((a ^ m_base[i]) & m_mask[i]) == '0) &&
          (m_mode[i] == 2'b00 || (m_mode[i] == 2'b01 && r) || (m_mode[i] == 2'b10 && !r)))
        return i;
    end
    return -1;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      m_en[i] = 0; m_base[i] = '0; m_mask[i] = '0; m_wait[i] = 0; m_mode[i] = 2'b00;
    end
  endtask

  task automatic cfg_write(input int idx, input bit en, input logic [AW-1:0] base,
                           input logic [AW-1:0] mask, input int w, input logic [1:0] mode);
    cfg_idx = IW'(idx); cfg_en = en; cfg_base = base; cfg_mask = mask;
    cfg_wait = WW'(w); cfg_mode = mode; cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
    m_en[idx] = en; m_base[idx] = base; m_mask[idx] = mask; m_wait[idx] = w; m_mode[idx] = mode;
  endtask

  // k counts negedges after the DECODE edge; abort_k > 0 releases as_n at that sample.
  task automatic access(input logic [AW-1:0] a, input logic r, input int abort_k);
    r_ack = -1; r_berr = -1; r_pulses = 0; r_both = 0; r_cs = '0; r_idx = '0; r_hv = 1'b0;
    as_n = 1'b0; addr = a; rw = r;
    @(negedge clk);
    for (int k = 1; k <= TO + 40; k++) begin
      @(negedge clk);
      if (k == 1) begin r_cs = cs; r_idx = hit_idx; r_hv = hit_valid; end
      if (cs_pulse) r_pulses++;
      if (!dtack_n && !berr_n) r_both = 1;
      if (!dtack_n && r_ack < 0) r_ack = k;
      if (!berr_n && r_berr < 0) r_berr = k;
      if (r_ack > 0 || r_berr > 0 || k == abort_k) break;
    end
    as_n = 1'b1;
    @(negedge clk);
    if (cs_pulse) r_pulses++;
    r_idle_ok = (cs == '0) && !cs_pulse && !hit_valid && (hit_idx == '0) && dtack_n &&
                berr_n && !busy;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({cs, cs_pulse, hit_idx, hit_valid, dtack_n, berr_n, busy} !==
        {16'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got cs=%h pulse=%b idx=%0d hv=%b dtack_n=%b berr_n=%b busy=%b, want 0/0/0/0/1/1/0",
               cs, cs_pulse, hit_idx, hit_valid, dtack_n, berr_n, busy);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    cfg_write(0, 1, 24'h000000, 24'hFC0000, 0, 2'b00);
    access(24'h001234, 1'b1, 0);
    n_cmp++;
    if (r_ack !== 1) begin n_fail++; $display("FAIL basic_ack_k: got %0d want 1", r_ack); end
    n_cmp++;
    if (r_cs !== 16'h0001) begin n_fail++; $display("FAIL basic_cs: got %h want 0001", r_cs); end
    n_cmp++;
    if (r_pulses !== 1) begin n_fail++; $display("FAIL basic_pulse: got %0d want 1", r_pulses); end
    n_cmp++;
    if (!r_idle_ok) begin n_fail++; $display("FAIL basic_release: got outputs active want idle"); end
  endtask

  task automatic test_wait();
    cfg_write(3, 1, 24'h400000, 24'hFFE000, 5, 2'b00);
    access(24'h401FFE, 1'b0, 0);
    n_cmp++;
    if (r_idx !== 4'd3 || !r_hv) begin
      n_fail++; $display("FAIL wait_idx: got %0d/%b want 3/1", r_idx, r_hv);
    end
    n_cmp++;
    if (r_ack !== 6) begin n_fail++; $display("FAIL wait_ack_k: got %0d want 6", r_ack); end
    cfg_write(3, 1, 24'h400000, 24'hFFE000, 5, 2'b01);
    access(24'h401FFE, 1'b0, 0);
    n_cmp++;
    if (r_berr !== TO || r_ack !== -1 || r_hv !== 1'b0) begin
      n_fail++; $display("FAIL wait_ro_berr: got berr=%0d ack=%0d hv=%b want %0d/-1/0",
                         r_berr, r_ack, r_hv, TO);
    end
  endtask

  task automatic test_overlap();
    cfg_write(2, 1, 24'h080000, 24'hFFFFFE, 0, 2'b00);
    cfg_write(7, 1, 24'h080000, 24'hFF0000, 2, 2'b00);
    access(24'h080000, 1'b1, 0);
    n_cmp++;
    if (r_cs !== 16'h0004 || r_idx !== 4'd2) begin
      n_fail++; $display("FAIL overlap_low: got cs=%h idx=%0d want 0004/2", r_cs, r_idx);
    end
    access(24'h080010, 1'b0, 0);
    n_cmp++;
    if (r_cs !== 16'h0080 || r_idx !== 4'd7 || r_ack !== 3) begin
      n_fail++; $display("FAIL overlap_high: got cs=%h idx=%0d ack=%0d want 0080/7/3",
                         r_cs, r_idx, r_ack);
    end
    access(24'h080010, 1'b1, 1);
    n_cmp++;
    if (r_ack !== -1 || !r_idle_ok) begin
      n_fail++; $display("FAIL wait_abort: got ack=%0d idle=%b want -1/1", r_ack, r_idle_ok);
    end
  endtask

  task automatic test_unmapped();
    access(24'hF00000, 1'b1, 0);
    n_cmp++;
    if (r_berr !== TO || r_ack !== -1 || r_both) begin
      n_fail++; $display("FAIL unmapped_berr: got berr=%0d ack=%0d both=%b want %0d/-1/0",
                         r_berr, r_ack, r_both, TO);
    end
    n_cmp++;
    if (!r_idle_ok) begin n_fail++; $display("FAIL unmapped_release: got active want idle"); end
    access(24'hF00000, 1'b0, 10);
    n_cmp++;
    if (r_berr !== -1 || r_ack !== -1 || !r_idle_ok) begin
      n_fail++; $display("FAIL berr_abort: got berr=%0d ack=%0d idle=%b want -1/-1/1",
                         r_berr, r_ack, r_idle_ok);
    end
  endtask

  task automatic test_reset_mid();
    cfg_write(5, 1, 24'hA00000, 24'hF00000, 10, 2'b00);
    as_n = 1'b0; addr = 24'hA00000; rw = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (cs !== 16'h0020 || !busy) begin
      n_fail++; $display("FAIL midwait_cs: got cs=%h busy=%b want 0020/1", cs, busy);
    end
    reset = 1'b1;
    cfg_idx = '0; cfg_en = 1'b1; cfg_base = '0; cfg_mask = '0; cfg_wait = '0;
    cfg_mode = 2'b00; cfg_we = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({cs, cs_pulse, hit_idx, hit_valid, dtack_n, berr_n, busy} !==
        {16'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_outputs: got cs=%h pulse=%b idx=%0d hv=%b dtack_n=%b berr_n=%b busy=%b",
               cs, cs_pulse, hit_idx, hit_valid, dtack_n, berr_n, busy);
    end
    reset = 1'b0; cfg_we = 1'b0; as_n = 1'b1;
    clear_model();
    @(negedge clk);
    access(24'hA00000, 1'b1, 0);
    n_cmp++;
    if (r_berr !== TO || r_ack !== -1) begin
      n_fail++; $display("FAIL postreset_disabled: got berr=%0d ack=%0d want %0d/-1",
                         r_berr, r_ack, TO);
    end
    access(24'h000000, 1'b0, 0);
    n_cmp++;
    if (r_berr !== TO || r_ack !== -1) begin
      n_fail++; $display("FAIL reset_cfg_ignored: got berr=%0d ack=%0d want %0d/-1",
                         r_berr, r_ack, TO);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int            j, exp;
      logic [AW-1:0] msk, a;
      logic          r;
      for (int c = 0; c < 2; c++) begin
        msk = ~AW'((1 << $urandom_range(4, 20)) - 1);
        cfg_write(int'($urandom_range(0, N - 1)), bit'($urandom_range(0, 3) != 0),
                  AW'($urandom), msk, int'($urandom_range(0, 3)), 2'($urandom));
      end
      j = int'($urandom_range(0, N - 1));
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom)
                                      : (m_base[j] ^ (AW'($urandom) & ~m_mask[j]));
      r = 1'($urandom);
      exp = model_hit(a, r);
      access(a, r, 0);
      n_cmp++;
      if (exp < 0) begin
        if (r_berr !== TO || r_ack !== -1 || r_cs !== '0 || r_hv !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_miss a=%h rw=%b: got berr=%0d ack=%0d cs=%h want berr=%0d no ack",
                   a, r, r_berr, r_ack, r_cs, TO);
        end
      end else if (r_ack !== m_wait[exp] + 1 || r_cs !== (16'h1 << exp) ||
                   r_idx !== IW'(exp) || !r_hv || r_pulses !== 1 || r_berr !== -1) begin
        n_fail++;
        $display("FAIL rand_hit a=%h rw=%b: got ack=%0d cs=%h idx=%0d pulses=%0d want ack=%0d region=%0d",
                 a, r, r_ack, r_cs, r_idx, r_pulses, m_wait[exp] + 1, exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1; as_n = 1'b1; rw = 1'b0; addr = '0; cfg_we = 1'b0; cfg_idx = '0;
    cfg_en = 1'b0; cfg_base = '0; cfg_mask = '0; cfg_wait = '0; cfg_mode = 2'b00;
    clear_model();
    @(negedge clk);
    test_reset();
    test_basic();
    test_wait();
    test_overlap();
    test_unmapped();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
